// File: rtl/core_uart_tx_pkg.sv
// core_uart_tx_pkg: definitions shared by the UART transmitter files.
//   tx_state_e : serializer FSM state encoding.
//   clog2()    : ceiling log2 constant function, shared with other 9x8 peripherals.
package core_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Ceiling log2 for widths; callers pass values >= 2.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/core_uart_tx_fifo.sv
// core_uart_tx_fifo: synchronous show-ahead FIFO. The head entry is held in a
// register, so o_data is registered and valid whenever o_empty is low.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_push, i_data  : write one entry (ignored while full)
//   i_pop           : consume the head entry (ignored while empty)
//   o_data          : registered head entry
//   o_count         : occupancy, 0..G_DEPTH
//   o_full, o_empty : registered status flags
module core_uart_tx_fifo
    import core_uart_tx_pkg::*;
#(
    parameter int G_WIDTH = 8,
    parameter int G_DEPTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [G_WIDTH-1:0]        i_data,
    output logic [G_WIDTH-1:0]        o_data,
    output logic [clog2(G_DEPTH):0]   o_count,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int AW = clog2(G_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(G_DEPTH);

    logic [G_WIDTH-1:0] mem_q [G_DEPTH];
    logic [G_WIDTH-1:0] rd_data_q;
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic [AW:0]        count_d;
    logic               full_q;
    logic               empty_q;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok = i_push && !full_q;
    assign pop_ok  = i_pop && !empty_q;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: storage and head register are deliberately not reset; their
    // contents are meaningless while the FIFO is empty, and leaving them out
    // of reset keeps the array mappable to distributed RAM.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
        // Head register: bypass the incoming byte when it becomes the head,
        // otherwise pre-fetch the entry behind the one being popped.
        if (push_ok && (count_q == '0 || (pop_ok && count_q == (AW + 1)'(1)))) begin
            rd_data_q <= i_data;
        end else if (pop_ok) begin
            rd_data_q <= mem_q[rd_ptr_q + 1'b1];
        end
    end

    assign o_data  = rd_data_q;
    assign o_count = count_q;
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/core_uart_tx.sv
// core_uart_tx: outport-driven UART transmitter (8N1 / 8N2) for the 9x8 core.
// Bytes written through the outport strobe are queued in a FIFO and sent LSB
// first; frames queued back to back are sent with no idle gap.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_wr, i_data : outport write strobe and byte
//   o_uart_tx    : registered serial line, idle high
//   o_busy       : registered, FIFO non-empty or frame in progress
//   o_full       : registered, FIFO holds G_FIFO_DEPTH entries
//   o_overflow   : one-cycle pulse after a write was dropped
module core_uart_tx
    import core_uart_tx_pkg::*;
#(
    parameter int G_CLK_PER_BIT = 100,
    parameter int G_FIFO_DEPTH  = 16,
    parameter int G_STOP_BITS   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int BW = clog2(G_CLK_PER_BIT);
    localparam int AW = clog2(G_FIFO_DEPTH);

    tx_state_e   state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
    logic        busy_d;
    logic        overflow_q;

    logic [7:0]  fifo_rdata;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    logic        bit_end;
    logic        last_stop;
    logic        frame_end;
    logic        go_idle;

    core_uart_tx_fifo #(
        .G_WIDTH (8),
        .G_DEPTH (G_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_wr),
        .i_pop   (fifo_pop),
        .i_data  (i_data),
        .o_data  (fifo_rdata),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign bit_end   = (baud_q == BW'(G_CLK_PER_BIT - 1));
    assign last_stop = (bit_q == 3'(G_STOP_BITS - 1));
    assign frame_end = (state_q == STOP) && bit_end && last_stop;

    // A byte is popped on the same edge the start bit is driven, both from
    // IDLE and straight out of the final stop bit.
    assign fifo_pop = !fifo_empty && ((state_q == IDLE) || frame_end);

    // The FSM lands in IDLE only when the FIFO is empty; busy then depends
    // solely on whether a byte is being written on this edge.
    assign go_idle = fifo_empty && ((state_q == IDLE) || frame_end);
    assign busy_d  = (i_wr && !fifo_full) || !go_idle;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            overflow_q <= i_wr && fifo_full;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= START;
                        shift_q <= fifo_rdata;
                        tx_q    <= 1'b0;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            bit_q   <= '0;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (last_stop) begin
                            bit_q <= '0;
                            if (!fifo_empty) begin
                                state_q <= START;
                                shift_q <= fifo_rdata;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO occupancy can never exceed its depth.
    a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
        fifo_count <= (AW + 1)'(G_FIFO_DEPTH));

    assign o_uart_tx  = tx_q;
    assign o_busy     = busy_q;
    assign o_full     = fifo_full;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_core_uart_tx.sv
// Testbench for core_uart_tx. Two instances: dut0 (4 clocks/bit, depth 4,
// one stop bit) and dut1 (4 clocks/bit, depth 4, two stop bits). Every
// accepted write pushes the expected byte and start cycle into a queue; a
// serial monitor per instance pops it when a start bit appears and compares
// the whole frame waveform.
module tb_core_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FL0   = (9 + 1) * CPB;
    localparam int FL1   = (9 + 2) * CPB;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr0 = 1'b0;
    logic       wr1 = 1'b0;
    logic [7:0] data0 = '0;
    logic [7:0] data1 = '0;
    logic       tx0, busy0, full0, ovf0;
    logic       tx1, busy1, full1, ovf1;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;
    int   free0    = 0;
    int   free1    = 0;
    int   frames0  = 0;
    int   frames1  = 0;
    int   unexp    = 0;
    int   ovf_cnt0 = 0;
    bit   abort0   = 1'b0;
    bit   mon_go   = 1'b0;

    always #5 clk = ~clk;

    core_uart_tx #(.G_CLK_PER_BIT(CPB), .G_FIFO_DEPTH(DEPTH), .G_STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_wr(wr0), .i_data(data0),
        .o_uart_tx(tx0), .o_busy(busy0), .o_full(full0), .o_overflow(ovf0)
    );

    core_uart_tx #(.G_CLK_PER_BIT(CPB), .G_FIFO_DEPTH(DEPTH), .G_STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_wr(wr1), .i_data(data1),
        .o_uart_tx(tx1), .o_busy(busy1), .o_full(full1), .o_overflow(ovf1)
    );

    always @(posedge clk) ncyc <= ncyc + 1;
    always @(posedge clk) if (ovf0 === 1'b1) ovf_cnt0 <= ovf_cnt0 + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, ncyc);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        check(name, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic wait_until(input int c);
        while (ncyc < c) @(negedge clk);
    endtask

    // Drive one write for one cycle; 'accept' is the hand-derived outcome.
    task automatic wr(input int which, input logic [7:0] d, input bit accept);
        exp_t e;
        int   st;
        if (which == 0) begin wr0 = 1'b1; data0 = d; end
        else            begin wr1 = 1'b1; data1 = d; end
        if (accept) begin
            e.data = d;
            if (which == 0) begin
                st = (ncyc + 2 > free0) ? ncyc + 2 : free0;
                free0 = st + FL0;
                e.start = st;
                sb0.push_back(e);
            end else begin
                st = (ncyc + 2 > free1) ? ncyc + 2 : free1;
                free1 = st + FL1;
                e.start = st;
                sb1.push_back(e);
            end
        end
        @(negedge clk);
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (n < 2000 && ((which == 0) ? (sb0.size() != 0 || busy0 !== 1'b0)
                                         : (sb1.size() != 0 || busy1 !== 1'b0))) begin
            @(negedge clk);
            n++;
        end
        check_bit("drain_done", (n < 2000), 1'b1);
    endtask

    task automatic rx_monitor(input int which);
        int         fl, start, err, b;
        exp_t       e;
        logic [7:0] got;
        logic       s, exp_lvl;
        bit         have_exp, aborted;
        fl = (which == 0) ? FL0 : FL1;
        forever begin
            @(negedge clk);
            if (which == 0 && abort0) begin
                sb0.delete();
                abort0 = 1'b0;
                continue;
            end
            s = (which == 0) ? tx0 : tx1;
            if (s === 1'b0) begin
                start = ncyc;
                if (which == 0) frames0++; else frames1++;
                have_exp = ((which == 0) ? sb0.size() : sb1.size()) != 0;
                if (have_exp) e = (which == 0) ? sb0.pop_front() : sb1.pop_front();
                else begin
                    unexp++;
                    e.data  = '0;
                    e.start = start;
                end
                err     = 0;
                got     = '0;
                aborted = 1'b0;
                for (int i = 1; i < fl; i++) begin
                    @(negedge clk);
                    if (which == 0 && abort0) begin
                        aborted = 1'b1;
                        break;
                    end
                    s = (which == 0) ? tx0 : tx1;
                    b = i / CPB;
                    exp_lvl = (b == 0) ? 1'b0 : (b <= 8) ? e.data[b-1] : 1'b1;
                    if (s !== exp_lvl) err++;
                    if (b >= 1 && b <= 8 && (i % CPB) == CPB / 2) got[b-1] = s;
                end
                if (!aborted && have_exp) begin
                    check("start_time", start, e.start);
                    check("rx_byte", {24'b0, got}, {24'b0, e.data});
                    check("frame_shape", err, 0);
                end
            end
        end
    endtask

    initial begin
        wait (mon_go);
        rx_monitor(0);
    end

    initial begin
        wait (mon_go);
        rx_monitor(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cycle=%0d", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, base, fr;

        // Reset state.
        repeat (3) @(negedge clk);
        check_bit("rst_tx0", tx0, 1'b1);
        check_bit("rst_busy0", busy0, 1'b0);
        check_bit("rst_full0", full0, 1'b0);
        check_bit("rst_ovf0", ovf0, 1'b0);
        check_bit("rst_tx1", tx1, 1'b1);
        check_bit("rst_busy1", busy1, 1'b0);
        rst    = 1'b0;
        mon_go = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5; start bit one cycle after the write edge.
        w = ncyc;
        check_bit("busy_pre_wr", busy0, 1'b0);
        wr(0, 8'hA5, 1'b1);
        check_bit("busy_after_wr", busy0, 1'b1);
        wait_until(w + 41);
        check_bit("busy_last_stop", busy0, 1'b1);
        wait_until(w + 42);
        check_bit("busy_fall", busy0, 1'b0);
        drain(0);

        // Back-to-back frames.
        wr(0, 8'h00, 1'b1);
        wr(0, 8'hFF, 1'b1);
        drain(0);

        // Full / overflow: bytes 1..5 accepted, byte 6 dropped.
        base = ovf_cnt0;
        w    = ncyc;
        for (int i = 1; i <= 6; i++) begin
            check_bit("full_before_wr", full0, (i == 6));
            check_bit("ovf_before_wr", ovf0, 1'b0);
            wr(0, 8'(i), (i <= 5));
        end
        check_bit("ovf_pulse", ovf0, 1'b1);
        check_bit("full_held", full0, 1'b1);
        @(negedge clk);
        check_bit("ovf_one_cycle", ovf0, 1'b0);
        wait_until(w + 41);
        check_bit("full_before_pop", full0, 1'b1);
        wait_until(w + 42);
        check_bit("full_after_pop", full0, 1'b0);
        drain(0);
        check("ovf_count", ovf_cnt0 - base, 1);

        // Two stop bits: 44-cycle frame.
        w = ncyc;
        wr(1, 8'h3C, 1'b1);
        wait_until(w + 45);
        check_bit("stop2_busy_last", busy1, 1'b1);
        wait_until(w + 46);
        check_bit("stop2_busy_fall", busy1, 1'b0);
        drain(1);

        // Pointer wrap: 40 bytes, FIFO kept partially full.
        base = ovf_cnt0;
        for (int i = 0; i < 40; i++) begin
            wr(0, 8'(i), 1'b1);
            if (i >= 2) repeat (39) @(negedge clk);
        end
        drain(0);
        check("wrap_no_ovf", ovf_cnt0 - base, 0);

        // Reset during data bit 3 of the first of three queued bytes.
        w = ncyc;
        wr(0, 8'hA1, 1'b1);
        wr(0, 8'hB2, 1'b1);
        wr(0, 8'hC3, 1'b1);
        wait_until(w + 19);
        fr     = frames0;
        abort0 = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("midrst_tx", tx0, 1'b1);
        check_bit("midrst_busy", busy0, 1'b0);
        check_bit("midrst_full", full0, 1'b0);
        free0 = 0;
        repeat (150) @(negedge clk);
        check("midrst_no_frames", frames0, fr);
        check_bit("midrst_tx_idle", tx0, 1'b1);
        check_bit("midrst_busy_idle", busy0, 1'b0);
        check("midrst_sb_flushed", sb0.size(), 0);
        check("unexpected_frames", unexp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_uart_tx.md
# core_uart_tx

Outport-driven UART transmitter peripheral for the 9x8 processor core. The core writes bytes through an outport strobe into a small synchronous FIFO. A serializer drains the FIFO as 8N1/8N2 frames on a single serial line. Busy and full status are exposed for the core to poll through an inport.

## Interface

Parameters:
- G_CLK_PER_BIT, default 100: clock cycles per serial bit; legal range 2..65535.
- G_FIFO_DEPTH, default 16: FIFO entries; power of two, 2..256.
- G_STOP_BITS, default 1: number of stop bits, 1 or 2.

Ports:
- i_clk  in  1  processor clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wr  in  1  outport write strobe; one byte per high cycle.
- i_data  in  8  byte to transmit; sampled when i_wr is high.
- o_uart_tx  out  1  serial output; idle high; registered.
- o_busy  out  1  FIFO non-empty or a frame in progress; registered.
- o_full  out  1  FIFO holds G_FIFO_DEPTH entries; registered.
- o_overflow  out  1  one-cycle pulse when a write is dropped.

## Operation

- Reset values: o_uart_tx=1, o_busy=0, o_full=0, o_overflow=0. FIFO is empty, FSM is in IDLE, bit and baud counters are 0.
- Write path: on an edge with i_wr=1 and o_full=0, i_data is pushed. If o_full=1, the write is dropped and o_overflow pulses for one cycle. A pop in the same cycle does not rescue a write made while o_full=1.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge the byte is popped into the shift register and o_uart_tx goes to 0.
  - START lasts G_CLK_PER_BIT cycles, then → DATA.
  - DATA sends 8 bits LSB first, each for G_CLK_PER_BIT cycles, then → STOP.
  - STOP holds o_uart_tx=1 for G_STOP_BITS×G_CLK_PER_BIT cycles.
  - At the end of STOP: if the FIFO is non-empty, go directly to START (pop, line low on the same edge, no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..G_CLK_PER_BIT−1 and restarts on every bit boundary. Width is clog2(G_CLK_PER_BIT).
- FIFO pointers: clog2(G_FIFO_DEPTH) bits, wrapping modulo the depth. A separate occupancy count of clog2(G_FIFO_DEPTH)+1 bits distinguishes full from empty.
- Simultaneous push and pop with 0 < count < depth: count is unchanged and data order is preserved.
- o_busy = (count≠0) OR (state≠IDLE), registered.
- Reset mid-frame: on the next edge o_uart_tx=1, FIFO is emptied, FSM goes to IDLE. The partial frame is abandoned and any queued bytes are discarded.

## Timing

- Write sampled at edge N → o_busy=1 after edge N.
- FIFO non-empty is seen at edge N+1, which pops the byte and drives o_uart_tx low. Write-to-start-bit latency is 1 cycle.
- Frame length is (10 + G_STOP_BITS − 1) × G_CLK_PER_BIT cycles.
- Back-to-back frames are exactly contiguous.
- o_busy falls on the edge where STOP completes with the FIFO empty.
- o_full rises on the edge after the push that reaches G_FIFO_DEPTH.
- o_full falls on the edge after the first pop from a full FIFO.
- o_overflow asserts on the edge following the dropped write and lasts exactly one cycle.

## Structure

- Shared package core_uart_tx_pkg:
  - FSM state encoding localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - clog2 constant function, shared with other 9x8 peripherals.
- Sub-module core_uart_tx_fifo:
  - Synchronous FIFO with push, pop, data in/out, count, full, empty.
  - Parameterized by width and depth.
  - Memory inferred as distributed RAM with registered read data.
  - The top level holds the FSM, baud counter, bit counter, shift register and status registers.

## Test plan

- Single byte, G_CLK_PER_BIT=4, G_STOP_BITS=1: write 8'hA5 once after reset. Required: o_uart_tx low exactly 1 cycle after the write, then bit sequence 0,1,0,1,0,0,1,0,1,1 in 4-cycle bits. o_busy drops after 40 cycles.
- Back-to-back: write 8'h00 then 8'hFF on consecutive cycles. Required: two 40-cycle frames with no idle cycle between the stop bit of frame 1 and the start bit of frame 2.
- Full/overflow, G_FIFO_DEPTH=4: write 6 bytes 1..6 on consecutive cycles.
  - Byte 1 pops immediately; bytes 2..5 fill the FIFO and o_full=1.
  - Byte 6 is dropped with a single o_overflow pulse.
  - Serial output is 1,2,3,4,5.
- G_STOP_BITS=2: write 8'h3C. Required: frame lasts 44 cycles with 8 stop-bit cycles high.
- Reset mid-frame: queue 3 bytes, assert i_rst for 1 cycle during data bit 3. Required: o_uart_tx=1, o_busy=0, o_full=0 on the next edge, and no further frames.
- Pointer wrap: stream 40 bytes (values 0..39) while keeping the FIFO partially full. Required: all bytes are received in order with no loss and no o_overflow.
